// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu_if
// Brief    : EX->MEM request and MEM->WB response bundle of the load/store unit.
// Revision : 1.0
// ============================================================================
interface mem_stage_lsu_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALU_result;
    logic [31:0] WriteData;
    logic [31:0] MemData;
    logic        MemValid;
    logic        MemStall;
    logic        MemFault;

    modport master (
        output MemRead, MemWrite, funct3, ALU_result, WriteData,
        input  MemData, MemValid, MemStall, MemFault
    );

    modport slave (
        input  MemRead, MemWrite, funct3, ALU_result, WriteData,
        output MemData, MemValid, MemStall, MemFault
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : RV32I data-memory stage with sub-word access, fixed read latency
//            and fault flagging; stalls the pipeline while a load is in flight.
// Revision : 1.0
// ============================================================================
module mem_stage_lsu #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mem_stage_lsu_if.slave  mem_io
);
    localparam int          c_ADDR_W    = $clog2(DEPTH);
    localparam logic [32:0] c_MEM_BYTES = 33'(DEPTH) << 2;
    localparam logic [3:0]  c_LAT_M1    = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [c_ADDR_W-1:0]   widx_q;
    logic [1:0]            lane_q;
    logic [2:0]            f3_q;
    logic [31:0]           data_q;
    logic                  valid_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  w_fault_cond;
    logic                  w_idle;
    logic                  w_ld_go;
    logic                  w_st_go;
    logic [c_ADDR_W-1:0]   w_widx;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;

    function automatic logic [31:0] f_extend(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign w_widx = mem_io.ALU_result[c_ADDR_W+1:2];
    assign w_lane = mem_io.ALU_result[1:0];

    always_comb begin
        w_fault_cond = 1'b0;
        if (mem_io.MemRead && mem_io.MemWrite)
            w_fault_cond = 1'b1;
        if (mem_io.MemRead && (mem_io.funct3 == 3'd3 || mem_io.funct3[2:1] == 2'b11))
            w_fault_cond = 1'b1;
        if (mem_io.MemWrite && mem_io.funct3 > 3'd2)
            w_fault_cond = 1'b1;
        if (mem_io.funct3[1:0] == 2'b01 && mem_io.ALU_result[0])
            w_fault_cond = 1'b1;
        if (mem_io.funct3[1:0] == 2'b10 && mem_io.ALU_result[1:0] != 2'b00)
            w_fault_cond = 1'b1;
        if ({1'b0, mem_io.ALU_result} >= c_MEM_BYTES)
            w_fault_cond = 1'b1;
    end

    // rst_n gates the combinational outputs so they fall with the async reset.
    assign w_idle  = rst_n && (state_q == ST_IDLE);
    assign w_ld_go = w_idle && mem_io.MemRead  && !w_fault_cond;
    assign w_st_go = w_idle && mem_io.MemWrite && !w_fault_cond;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_io.WriteData;
        case (mem_io.funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{mem_io.WriteData[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_io.WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_st_go) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    mem_q[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Extended data is captured on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            widx_q  <= '0;
            lane_q  <= 2'd0;
            f3_q    <= 3'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_ld_go) begin
                        widx_q <= w_widx;
                        lane_q <= w_lane;
                        f3_q   <= mem_io.funct3;
                        cnt_q  <= c_LAT_M1;
                        if (READ_LATENCY > 1) begin
                            state_q <= ST_WAIT;
                        end else begin
                            data_q  <= f_extend(mem_q[w_widx], w_lane, mem_io.funct3);
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        data_q  <= f_extend(mem_q[widx_q], lane_q, f3_q);
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_q  <= 32'd0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_io.MemData  = data_q;
    assign mem_io.MemValid = valid_q;
    assign mem_io.MemStall = w_ld_go || (state_q == ST_WAIT);
    assign mem_io.MemFault = w_idle && (mem_io.MemRead || mem_io.MemWrite) && w_fault_cond;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Three LSU instances (read latency 1, 2, 5) driven as a stalling
//            pipeline would, compared each cycle against a byte-array model.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_lsu;
    localparam int DEPTH = 256;
    localparam int NB    = 4 * DEPTH;
    localparam int NI    = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
    endfunction

    // chk: 0 model only, 1 literal load data, 2 literal fault
    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          chk;
        logic [31:0] lit;
    } req_t;

    logic                clk = 1'b0;
    logic [NI-1:0]       rst_n;
    logic [NI-1:0]       rd_s, wr_s;
    logic [NI-1:0][2:0]  f3_s;
    logic [NI-1:0][31:0] addr_s, wd_s, md_o;
    logic [NI-1:0]       mv_o, ms_o, mf_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        mem_stage_lsu_if bus ();
        assign bus.MemRead    = rd_s[g];
        assign bus.MemWrite   = wr_s[g];
        assign bus.funct3     = f3_s[g];
        assign bus.ALU_result = addr_s[g];
        assign bus.WriteData  = wd_s[g];
        assign md_o[g]        = bus.MemData;
        assign mv_o[g]        = bus.MemValid;
        assign ms_o[g]        = bus.MemStall;
        assign mf_o[g]        = bus.MemFault;
        mem_stage_lsu #(.DEPTH(DEPTH), .READ_LATENCY(lat_of(g))) u_dut (
            .clk    (clk),
            .rst_n  (rst_n[g]),
            .mem_io (bus)
        );
    end

    logic [7:0]  ref_mem [NI][NB];
    req_t        dir [$];
    int          dptr [NI];
    req_t        cur [NI];
    bit          have [NI];
    bit          busy [NI];
    int          age [NI];
    logic [31:0] ld_exp [NI];
    logic [31:0] ld_lit [NI];
    int          ld_chk [NI];
    bit          rand_on;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [lat=%0d] t=%0t got=%h want=%h", nm, lat_of(k), $time, act, exp);
        end
    endtask

    function automatic req_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int chk, input logic [31:0] lit);
        req_t r;
        r.rd = rd; r.wr = wr; r.f3 = f3; r.addr = addr; r.wdata = wdata; r.chk = chk; r.lit = lit;
        return r;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit f_fault(input req_t r);
        if (!r.rd && !r.wr) return 1'b0;
        if (r.rd && r.wr) return 1'b1;
        if (r.addr >= 32'(NB)) return 1'b1;
        if (r.rd && (r.f3 == 3'd3 || r.f3 >= 3'd6)) return 1'b1;
        if (r.wr && r.f3 > 3'd2) return 1'b1;
        return (r.addr % 32'(size_of(r.f3))) != 32'd0;
    endfunction

    function automatic logic [31:0] f_load(input int k, input req_t r);
        logic [31:0] a;
        logic [7:0]  b0;
        a  = r.addr;
        b0 = ref_mem[k][a];
        case (r.f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd4:    return {24'h0, b0};
            3'd1:    return {{16{ref_mem[k][a+1][7]}}, ref_mem[k][a+1], b0};
            3'd5:    return {16'h0, ref_mem[k][a+1], b0};
            default: return {ref_mem[k][a+3], ref_mem[k][a+2], ref_mem[k][a+1], b0};
        endcase
    endfunction

    task automatic m_store(input int k, input req_t r);
        for (int i = 0; i < size_of(r.f3); i++)
            ref_mem[k][r.addr + 32'(i)] = r.wdata[8*i +: 8];
    endtask

    function automatic req_t rnd_req();
        req_t r;
        int   sel;
        int   t;
        sel  = int'($urandom_range(0, 9));
        r.rd = (sel >= 2 && sel <= 5) || sel == 9;
        r.wr = (sel >= 6);
        if ($urandom_range(0, 9) < 8) begin
            if (r.wr && !r.rd) begin
                r.f3 = 3'($urandom_range(0, 2));
            end else begin
                t    = int'($urandom_range(0, 4));
                r.f3 = 3'((t > 2) ? t + 1 : t);
            end
        end else begin
            r.f3 = 3'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 19) == 0)
            r.addr = ($urandom_range(0, 1) == 0) ? 32'(NB) + $urandom_range(0, 15) : $urandom();
        else
            r.addr = $urandom_range(0, NB - 1);
        if ($urandom_range(0, 4) != 0)
            r.addr = r.addr & ~32'(size_of(r.f3) - 1);
        r.wdata = $urandom();
        r.chk   = 0;
        r.lit   = 32'd0;
        return r;
    endfunction

    task automatic drive(input int k, input req_t r);
        rd_s[k]   = r.rd;
        wr_s[k]   = r.wr;
        f3_s[k]   = r.f3;
        addr_s[k] = r.addr;
        wd_s[k]   = r.wdata;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NI; k++)
            if (dptr[k] < dir.size() || have[k] || busy[k]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: present the pipeline's request after the edge, compare at the falling edge.
    task automatic step();
        bit flt;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            req_t r;
            if (busy[k] && age[k] < lat_of(k)) begin
                r = rnd_req();
            end else begin
                if (!have[k]) begin
                    if (dptr[k] < dir.size()) begin
                        cur[k] = dir[dptr[k]];
                        dptr[k]++;
                    end else if (rand_on) begin
                        cur[k] = rnd_req();
                    end else begin
                        cur[k] = mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0, 32'd0);
                    end
                    have[k] = 1'b1;
                end
                r = cur[k];
            end
            drive(k, r);
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (busy[k]) begin
                if (age[k] < lat_of(k)) begin
                    check("stall_in_load", k, {31'b0, ms_o[k]}, 32'd1);
                    check("valid_in_load", k, {31'b0, mv_o[k]}, 32'd0);
                    check("data_in_load",  k, md_o[k], 32'd0);
                    check("fault_in_load", k, {31'b0, mf_o[k]}, 32'd0);
                    age[k]++;
                end else begin
                    check("valid_done", k, {31'b0, mv_o[k]}, 32'd1);
                    check("data_done",  k, md_o[k], ld_exp[k]);
                    check("stall_done", k, {31'b0, ms_o[k]}, 32'd0);
                    check("fault_done", k, {31'b0, mf_o[k]}, 32'd0);
                    if (ld_chk[k] == 1)
                        check("data_literal", k, md_o[k], ld_lit[k]);
                    busy[k] = 1'b0;
                    have[k] = 1'b0;
                end
            end else begin
                flt = f_fault(cur[k]);
                check("fault_idle", k, {31'b0, mf_o[k]}, {31'b0, flt});
                check("stall_idle", k, {31'b0, ms_o[k]}, {31'b0, cur[k].rd && !flt});
                check("valid_idle", k, {31'b0, mv_o[k]}, 32'd0);
                check("data_idle",  k, md_o[k], 32'd0);
                if (cur[k].chk == 2)
                    check("fault_literal", k, {31'b0, mf_o[k]}, 32'd1);
                if (!flt && cur[k].rd) begin
                    busy[k]   = 1'b1;
                    age[k]    = 1;
                    ld_exp[k] = f_load(k, cur[k]);
                    ld_chk[k] = cur[k].chk;
                    ld_lit[k] = cur[k].lit;
                end else begin
                    if (!flt && cur[k].wr) m_store(k, cur[k]);
                    have[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int bound, input string nm);
        int n;
        n = 0;
        while (!all_idle() && n < bound) begin
            step();
            n++;
        end
        if (!all_idle()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout after %0d cycles", nm, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ok;
        rst_n   = '0;
        rand_on = 1'b0;
        for (int k = 0; k < NI; k++) begin
            dptr[k] = 0; have[k] = 1'b0; busy[k] = 1'b0; age[k] = 0; ld_chk[k] = 0;
            drive(k, mk(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 0, 32'd0));
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("reset_data",  k, md_o[k], 32'd0);
            check("reset_valid", k, {31'b0, mv_o[k]}, 32'd0);
            check("reset_stall", k, {31'b0, ms_o[k]}, 32'd0);
            check("reset_fault", k, {31'b0, mf_o[k]}, 32'd0);
            drive(k, mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0, 32'd0));
        end
        @(negedge clk);
        rst_n = '1;

        for (int w = 0; w < DEPTH; w++)
            dir.push_back(mk(1'b0, 1'b1, 3'd2, 32'(4 * w), $urandom(), 0, 32'd0));
        dir.push_back(mk(1'b0, 1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h10,  32'd0,        1, 32'hDEADBEEF));
        dir.push_back(mk(1'b0, 1'b1, 3'd2, 32'h20,  32'h11223344, 0, 32'd0));
        dir.push_back(mk(1'b0, 1'b1, 3'd0, 32'h21,  32'h12345680, 0, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd0, 32'h21,  32'd0,        1, 32'hFFFFFF80));
        dir.push_back(mk(1'b1, 1'b0, 3'd4, 32'h21,  32'd0,        1, 32'h00000080));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h20,  32'd0,        1, 32'h11228044));
        dir.push_back(mk(1'b0, 1'b1, 3'd2, 32'h30,  32'h00000000, 0, 32'd0));
        dir.push_back(mk(1'b0, 1'b1, 3'd1, 32'h32,  32'hABCD8001, 0, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd1, 32'h32,  32'd0,        1, 32'hFFFF8001));
        dir.push_back(mk(1'b1, 1'b0, 3'd5, 32'h32,  32'd0,        1, 32'h00008001));
        dir.push_back(mk(1'b0, 1'b1, 3'd1, 32'h33,  32'h0000FFFF, 2, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h30,  32'd0,        1, 32'h80010000));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h102, 32'd0,        2, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h402, 32'd0,        2, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h400, 32'd0,        2, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd3, 32'h10,  32'd0,        2, 32'd0));
        dir.push_back(mk(1'b1, 1'b1, 3'd2, 32'h10,  32'h0BADF00D, 2, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h10,  32'd0,        1, 32'hDEADBEEF));
        drain(2000, "directed");

        rand_on = 1'b1;
        repeat (1500) step();
        rand_on = 1'b0;
        drain(50, "random_drain");

        dir.push_back(mk(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 0, 32'd0));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h40, 32'd0,        0, 32'd0));
        n = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            step();
            n++;
            ok = 1'b1;
            for (int k = 0; k < NI; k++)
                if (!(busy[k] && age[k] == 1)) ok = 1'b0;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL midload_setup timeout after %0d cycles", n);
        end
        @(posedge clk);
        #2;
        rst_n = '0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("midreset_stall", k, {31'b0, ms_o[k]}, 32'd0);
            check("midreset_valid", k, {31'b0, mv_o[k]}, 32'd0);
            check("midreset_data",  k, md_o[k], 32'd0);
            check("midreset_fault", k, {31'b0, mf_o[k]}, 32'd0);
            busy[k] = 1'b0;
            have[k] = 1'b0;
            drive(k, mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0, 32'd0));
        end
        @(negedge clk);
        rst_n = '1;
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 1, 32'hCAFEF00D));
        dir.push_back(mk(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 0, 32'd0));
        drain(50, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
